rr_quantum_bus_scheduler: RTL and testbench
===========================================

Name: rr_quantum_bus_scheduler

Overview:
Shares one bus/resource among NUM_REQ requesters using rotating (round-robin) priority. Each grant is held while the owner keeps its request up, but is limited to a QUANTUM-cycle time slice whenever another requester is waiting. One dead turnaround cycle separates consecutive owners. Sits between the requesting masters and the shared bus mux, and drives the mux select directly.

Parameters:
NUM_REQ, 4, number of requesters (2..16).
QUANTUM, 8, maximum grant cycles while contention exists (>=1).
IDX_W, 2, width of grant_idx; must equal ceil(log2(NUM_REQ)).

Ports:
clock  input  1  rising-edge clock; the only clock.
reset  input  1  synchronous, active-high reset.
req  input  NUM_REQ  level request per requester; held until the requester is done.
grant  output  NUM_REQ  registered one-hot grant; all-zero when no owner.
grant_idx  output  IDX_W  encoded owner index; holds the last owner when grant is 0.
bus_busy  output  1  OR of grant.
preempt  output  1  one-cycle pulse when a grant is revoked by quantum expiry.

Behaviour:
- Reset: grant=0, grant_idx=0, bus_busy=0, preempt=0, state=IDLE, slice counter=0, rotate pointer=NUM_REQ-1 (req[0] has highest priority first).
- All outputs are registered. No combinational path from req to any output.
- Arbitration rule: pick the first asserted req scanning ptr+1, ptr+2, ... modulo NUM_REQ. ptr is the last owner.
- State IDLE:
  - If any req is high at edge k, the selected grant bit is high from edge k onward (1-cycle latency).
  - Go to GRANT; counter=1.
  - If no req is high, stay in IDLE.
- State GRANT, evaluated each edge in this priority order:
  - (a) req[owner]=0: clear grant, set ptr=owner, go to HANDOVER.
  - (b) counter==QUANTUM and any other req is high: clear grant, preempt=1 for one cycle, set ptr=owner, go to HANDOVER.
  - (c) Otherwise keep the grant; counter increments and saturates at QUANTUM.
  - Sole requester: never preempted, even past QUANTUM cycles.
- State HANDOVER: grant=0 for exactly one cycle. Arbitration is performed at the end of this cycle.
  - Any req high: go to GRANT with the new owner, counter=1.
  - Otherwise: go to IDLE.
  - A preempted owner that still requests is eligible, but gets lowest priority because ptr=owner.
- A req dropping while not granted has no effect. A req rising and falling between edges is not captured.
- Reset asserted mid-grant: grant drops at that edge; state and pointer return to reset values.
- grant is never multi-hot and never changes owner without an intervening all-zero cycle.

Optional Feature:
RRQ_LOCK_EN:
- Defined: adds input lock [NUM_REQ] (locked transfer).
  - While lock[owner]=1, rule (b) is suppressed and the counter stays saturated.
  - Release happens only via rule (a). lock from non-owners is ignored.
  - When lock[owner] drops, rule (b) applies at the next edge if the counter==QUANTUM and contention exists.
- Undefined: no lock port; quantum preemption always applies.

Test Plan:
1. Reset, then req=0001 at edge 1 -> grant=0001 and grant_idx=0 from edge 1; drop req -> grant=0000 next edge; HANDOVER then IDLE.
2. req=1111 held constantly, QUANTUM=8 -> grants 0001,0010,0100,1000,0001 in sequence. Each lasts 8 cycles, separated by one zero cycle, with a preempt pulse at each revoke.
3. req=0100 alone for 20 cycles -> grant=0100 continuously, preempt never asserts.
4. Owner 1 granted, req[1] drops at cycle 3 while req=1001 -> one zero cycle, then grant=1000 (3 follows 1 in rotation).
5. Reset asserted during a grant to requester 2 with req=0101 -> grant=0000 at the reset edge. After release, grant=0001 (pointer reset).
6. RRQ_LOCK_EN, owner 0 with lock[0]=1, req=0011 for 20 cycles -> no preempt. Drop lock[0] at cycle 20 -> preempt next edge, then grant=0010 after one zero cycle.

Source files
------------

// File: rtl/rr_quantum_bus_scheduler.sv
// Round-robin bus scheduler with a quantum-limited time slice and one dead turnaround cycle.
// Optional `define RRQ_LOCK_EN adds a per-requester lock input that suppresses quantum preemption.
module rr_quantum_bus_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned QUANTUM = 8,
    parameter int unsigned IDX_W   = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
`ifdef RRQ_LOCK_EN
    input  logic [NUM_REQ-1:0] lock,
`endif
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               bus_busy,
    output logic               preempt
);

    localparam int unsigned CNT_W = $clog2(QUANTUM + 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_GRANT    = 2'd1;
    localparam logic [1:0] ST_HANDOVER = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic               bus_busy_q, bus_busy_d;
    logic               preempt_q, preempt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic               any_req;
    logic               others_req;
    logic               owner_locked;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    int unsigned        cand;

`ifdef RRQ_LOCK_EN
    assign owner_locked = lock[grant_idx_q];
`else
    assign owner_locked = 1'b0;
`endif

    assign any_req    = |req;
    assign others_req = |(req & ~grant_q);

    // Scan ptr+1, ptr+2, ... so the last owner ends up with lowest priority.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        cand      = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (32'(ptr_q) + i) % NUM_REQ;
            if (!sel_found && req[IDX_W'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        preempt_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_HANDOVER: begin
                grant_d = '0;
                if (any_req) begin
                    grant_d[sel_idx] = 1'b1;
                    grant_idx_d      = sel_idx;
                    cnt_d            = CNT_W'(1);
                    state_d          = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req[grant_idx_q]) begin
                    grant_d = '0;
                    ptr_d   = grant_idx_q;
                    state_d = ST_HANDOVER;
                end else if (cnt_q == CNT_W'(QUANTUM) && others_req && !owner_locked) begin
                    grant_d   = '0;
                    preempt_d = 1'b1;
                    ptr_d     = grant_idx_q;
                    state_d   = ST_HANDOVER;
                end else if (cnt_q != CNT_W'(QUANTUM)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
        bus_busy_d = |grant_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            bus_busy_q  <= 1'b0;
            preempt_q   <= 1'b0;
            cnt_q       <= '0;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            bus_busy_q  <= bus_busy_d;
            preempt_q   <= preempt_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign bus_busy  = bus_busy_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_quantum_bus_scheduler.sv
// Directed bench for rr_quantum_bus_scheduler: expected outputs queued per step, checked after the edge.
// Build with +define+RRQ_LOCK_EN to include the locked-transfer steps.
module tb_rr_quantum_bus_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req;
`ifdef RRQ_LOCK_EN
    logic [3:0] lock;
`endif
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       bus_busy;
    logic       preempt;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] idx;
        logic       busy;
        logic       pre;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    rr_quantum_bus_scheduler #(
        .NUM_REQ (4),
        .QUANTUM (8),
        .IDX_W   (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
`ifdef RRQ_LOCK_EN
        .lock      (lock),
`endif
        .grant     (grant),
        .grant_idx (grant_idx),
        .bus_busy  (bus_busy),
        .preempt   (preempt)
    );

    // Drive req, queue the outputs required after the next edge, then compare at edge+1.
    task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] ei,
                        input logic ep, input string tag);
        exp_t e;
        exp_t got;
        req    = r;
        e.grant = eg;
        e.idx   = ei;
        e.busy  = |eg;
        e.pre   = ep;
        e.tag   = tag;
        sb.push_back(e);
        @(posedge clock);
        #1;
        got = sb.pop_front();
        checks++;
        assert (grant === got.grant) else begin
            errors++;
            $error("FAIL %s grant observed=%b expected=%b", got.tag, grant, got.grant);
        end
        checks++;
        assert (grant_idx === got.idx) else begin
            errors++;
            $error("FAIL %s grant_idx observed=%0d expected=%0d", got.tag, grant_idx, got.idx);
        end
        checks++;
        assert (bus_busy === got.busy) else begin
            errors++;
            $error("FAIL %s bus_busy observed=%b expected=%b", got.tag, bus_busy, got.busy);
        end
        checks++;
        assert (preempt === got.pre) else begin
            errors++;
            $error("FAIL %s preempt observed=%b expected=%b", got.tag, preempt, got.pre);
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
`ifdef RRQ_LOCK_EN
        lock  = '0;
`endif
        // Reset values; req is ignored while reset is high.
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "reset");
        step(4'b1111, 4'b0000, 2'd0, 1'b0, "reset_req_masked");
        reset = 1'b0;

        // Single request, one-cycle latency, release, handover, idle.
        step(4'b0001, 4'b0001, 2'd0, 1'b0, "t1_grant");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "t1_release");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "t1_handover");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "t1_idle");

        // Fresh pointer so requester 0 wins first under full contention.
        reset = 1'b1;
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "t2_reset");
        reset = 1'b0;
        for (int o = 0; o < 5; o++) begin
            for (int c = 0; c < 8; c++)
                step(4'b1111, 4'b0001 << (o % 4), 2'(o % 4), 1'b0, "t2_slice");
            step(4'b1111, 4'b0000, 2'(o % 4), 1'b1, "t2_preempt");
        end

        // Sole requester keeps the bus past the quantum.
        for (int c = 0; c < 20; c++)
            step(4'b0100, 4'b0100, 2'd2, 1'b0, "t3_sole");
        step(4'b0000, 4'b0000, 2'd2, 1'b0, "t3_release");
        step(4'b0000, 4'b0000, 2'd2, 1'b0, "t3_idle");

        // Owner 1 drops while 0 and 3 wait: 3 follows 1 in rotation.
        step(4'b0010, 4'b0010, 2'd1, 1'b0, "t4_grant1");
        step(4'b1011, 4'b0010, 2'd1, 1'b0, "t4_hold2");
        step(4'b1011, 4'b0010, 2'd1, 1'b0, "t4_hold3");
        step(4'b1001, 4'b0000, 2'd1, 1'b0, "t4_drop");
        step(4'b1001, 4'b1000, 2'd3, 1'b0, "t4_next3");
        step(4'b1001, 4'b1000, 2'd3, 1'b0, "t4_hold");

        // Reset in the middle of a grant to requester 2.
        step(4'b0100, 4'b0000, 2'd3, 1'b0, "t5_drop3");
        step(4'b0100, 4'b0100, 2'd2, 1'b0, "t5_grant2");
        step(4'b0101, 4'b0100, 2'd2, 1'b0, "t5_hold");
        reset = 1'b1;
        step(4'b0101, 4'b0000, 2'd0, 1'b0, "t5_reset_edge");
        reset = 1'b0;
        step(4'b0101, 4'b0001, 2'd0, 1'b0, "t5_ptr_reset");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "t5_release");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "t5_idle");

`ifdef RRQ_LOCK_EN
        // Locked owner keeps the bus under contention until the lock drops.
        reset = 1'b1;
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "t6_reset");
        reset = 1'b0;
        lock  = 4'b0001;
        for (int c = 0; c < 20; c++)
            step(4'b0011, 4'b0001, 2'd0, 1'b0, "t6_locked");
        lock = 4'b0000;
        step(4'b0011, 4'b0000, 2'd0, 1'b1, "t6_unlock_preempt");
        step(4'b0011, 4'b0010, 2'd1, 1'b0, "t6_next1");
        // Lock from a non-owner has no effect.
        lock = 4'b0001;
        for (int c = 0; c < 7; c++)
            step(4'b0011, 4'b0010, 2'd1, 1'b0, "t6_nonowner_lock");
        step(4'b0011, 4'b0000, 2'd1, 1'b1, "t6_nonowner_preempt");
        lock = 4'b0000;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
